multicycle_hazard_unit: RTL and testbench
=========================================

# multicycle_hazard_unit

Parametrised load-use and control hazard controller for the 5-stage pipeline, sitting beside the ID stage and driving PC, IF/ID and the ID/EX control-bubble mux. It generalises single-cycle load-use stall detection to an N-cycle load latency, using an internal scoreboard of in-flight loads. It adds per-operand use qualification, r0 exclusion, branch-taken flush, a global memory-wait freeze, a stall-reason code, and saturating performance counters.

## Interface
Parameters:
- REG_ADDR_W, 5: register index width.
- LOAD_LAT, 1: cycles from a load in EX until its data is forwardable to EX; legal range 1..8.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; everything is clocked on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- Id_Rs, Id_Rt  in  REG_ADDR_W  source registers of the instruction in ID.
- Id_UseRs, Id_UseRt  in  1  the ID instruction actually reads Rs / Rt.
- Ex_Rt  in  REG_ADDR_W  destination of the instruction in EX.
- Ex_MemRead  in  1  the instruction in EX is a load.
- Ex_BranchTaken  in  1  the branch or jump resolved in EX is taken.
- Mem_Wait  in  1  data memory busy; the whole pipeline is frozen.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register write enable.
- Control_Unit_Sel  out  1  1 = pass control to ID/EX, 0 = insert a bubble.
- IF_ID_Flush  out  1  clear IF/ID to a NOP.
- Stall_Reason  out  2  0 none, 1 load-use, 2 flush, 3 mem-wait.
- Stall_Cnt  out  CNT_W  count of load-use stall cycles, saturating.
- Flush_Cnt  out  CNT_W  count of flush cycles, saturating.

## Operation
**Scoreboard**
- Shift chain of LOAD_LAT-1 entries, each holding {valid, rd}. No storage exists when LOAD_LAT=1.
- Entry k holds the load that was in EX k+1 cycles ago.
- On each unfrozen cycle:
  - entry 0 takes {Ex_MemRead && Ex_Rt!=0, Ex_Rt};
  - every other entry shifts by one.
- The oldest entry drops out of the chain.

**Load-use hazard**
- A source matches a candidate when Use=1, Src!=0 and Src equals the candidate's rd.
- Candidates are:
  - the EX load (Ex_MemRead=1, Ex_Rt!=0);
  - any valid scoreboard entry.

**Priority per cycle, highest first**
- Mem_Wait=1:
  - PCWrite=0, IF_ID_Write=0, Control_Unit_Sel=1, IF_ID_Flush=0, Stall_Reason=3;
  - scoreboard and counters hold.
- Ex_BranchTaken=1:
  - PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, Control_Unit_Sel=0, Stall_Reason=2;
  - a simultaneous load-use hazard is ignored, because the ID instruction is wrong-path;
  - Flush_Cnt increments.
- Load-use hazard:
  - PCWrite=0, IF_ID_Write=0, Control_Unit_Sel=0, IF_ID_Flush=0, Stall_Reason=1;
  - Stall_Cnt increments.
- Otherwise: PCWrite=1, IF_ID_Write=1, Control_Unit_Sel=1, IF_ID_Flush=0, Stall_Reason=0.

**Other rules**
- Bubble cycles still shift the scoreboard. The EX load keeps aging while ID is held.
- Counters saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Control outputs are combinational from the current inputs and scoreboard state, with zero-cycle latency.
- Counters and scoreboard update on the clock edge.
- A consumer directly behind a load stalls exactly LOAD_LAT cycles.
- A consumer one instruction behind a load stalls LOAD_LAT-1 cycles.
- LOAD_LAT=1 reproduces classic single-bubble behaviour.
- Behaviour during a cycle with rst=1:
  - outputs are forced to PCWrite=0, IF_ID_Write=0, Control_Unit_Sel=0, IF_ID_Flush=0, Stall_Reason=0;
  - at the edge, the scoreboard clears to all-invalid and Stall_Cnt and Flush_Cnt clear to 0.
- Reset mid-stall discards all pending loads. The first cycle after reset sees only the EX-stage candidate.
- Mem_Wait asserted mid-stall extends the stall by exactly the number of Mem_Wait cycles; remaining stall cycles are preserved.

## Structure
- Shared package hazard_pkg holds:
  - the REG_ADDR_W default;
  - the Stall_Reason encodings: REASON_NONE, REASON_LOAD, REASON_FLUSH, REASON_MEMWAIT.
- Sub-module load_scoreboard contains:
  - the parametrised shift chain, with generate-guarded emptiness when LOAD_LAT=1;
  - the match logic: inputs src, use, advance; output hit.
- The top level holds the priority logic and the counters.

## Test plan
- LOAD_LAT=2; load to r5 in EX at cycle 0; ID has Id_Rs=5, Id_UseRs=1 -> PCWrite=0 and Control_Unit_Sel=0 in cycles 0 and 1, released in cycle 2; Stall_Cnt=2.
- LOAD_LAT=1; load to r0, or a load to r7 with Id_Rt=7 but Id_UseRt=0 -> no stall; Stall_Reason=0 throughout.
- LOAD_LAT=3; hazard pending; Ex_BranchTaken=1 in the same cycle -> IF_ID_Flush=1, PCWrite=1, Stall_Reason=2, Flush_Cnt=1, Stall_Cnt unchanged.
- LOAD_LAT=2; load to r4 in EX, Id_Rs=4; Mem_Wait=1 for 3 cycles starting at the second stall cycle -> 3 cycles of Stall_Reason=3, then one cycle of Stall_Reason=1, then released; Stall_Cnt=2.
- CNT_W=4; 20 consecutive load-use stall cycles -> Stall_Cnt saturates at 15. Then rst=1 for one cycle -> counters 0, scoreboard empty, and a following matching ID source with Ex_MemRead=0 does not stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and stall-reason encodings for the hazard unit
package hazard_pkg;

   // Default register index width for the 32-entry register file
   localparam int REG_ADDR_W_DEF = 5;

   // Why the front end is not advancing this cycle
   typedef enum logic [1:0] {
      REASON_NONE    = 2'd0,
      REASON_LOAD    = 2'd1,
      REASON_FLUSH   = 2'd2,
      REASON_MEMWAIT = 2'd3
   } reason_e;

endpackage

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - in-flight load tracker with ID source match logic
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears all entries)
//   advance           shift the chain this cycle (low while memory freezes the pipe)
//   ex_load, ex_rd    load currently in EX and its destination register
//   src_rs, use_rs    first ID source register and whether it is read
//   src_rt, use_rt    second ID source register and whether it is read
//   hit               some read source depends on a load whose data is not yet forwardable
module load_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  advance,
   input  logic                  ex_load,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic [REG_ADDR_W-1:0] src_rs,
   input  logic                  use_rs,
   input  logic [REG_ADDR_W-1:0] src_rt,
   input  logic                  use_rt,
   output logic                  hit
);

   function automatic logic src_match(input logic [REG_ADDR_W-1:0] src,
                                      input logic                  used,
                                      input logic [REG_ADDR_W-1:0] rd);
      return used && (src != '0) && (src == rd);
   endfunction

   // Loads to r0 never create a dependency, so they are not tracked at all
   logic ex_valid;
   logic ex_hit;
   logic chain_hit;

   assign ex_valid = ex_load && (ex_rd != '0);
   assign ex_hit   = ex_valid && (src_match(src_rs, use_rs, ex_rd) ||
                                  src_match(src_rt, use_rt, ex_rd));
   assign hit      = ex_hit || chain_hit;

   generate
      if (LOAD_LAT > 1) begin : g_chain
         localparam int N = LOAD_LAT - 1;

         // Entry k holds the load that sat in EX k+1 advancing cycles ago
         logic [N-1:0]          vld_q, vld_d;
         logic [REG_ADDR_W-1:0] rd_q [N];
         logic [REG_ADDR_W-1:0] rd_d [N];
         logic                  hit_c;

         always_comb begin
            vld_d = vld_q;
            rd_d  = rd_q;
            if (advance) begin
               vld_d[0] = ex_valid;
               rd_d[0]  = ex_rd;
               for (int k = 1; k < N; k++) begin
                  vld_d[k] = vld_q[k-1];
                  rd_d[k]  = rd_q[k-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= '0;
               for (int k = 0; k < N; k++) begin
                  rd_q[k] <= '0;
               end
            end else begin
               vld_q <= vld_d;
               for (int k = 0; k < N; k++) begin
                  rd_q[k] <= rd_d[k];
               end
            end
         end

         always_comb begin
            hit_c = 1'b0;
            for (int k = 0; k < N; k++) begin
               if (vld_q[k] && (src_match(src_rs, use_rs, rd_q[k]) ||
                                src_match(src_rt, use_rt, rd_q[k]))) begin
                  hit_c = 1'b1;
               end
            end
         end

         assign chain_hit = hit_c;
      end else begin : g_none
         // Single-cycle latency: only the EX load can ever be a hazard
         assign chain_hit = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/multicycle_hazard_unit.sv
// rtl/multicycle_hazard_unit.sv - N-cycle load-use and control hazard controller beside ID
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   Id_Rs, Id_Rt              ID-stage source registers
//   Id_UseRs, Id_UseRt        ID instruction actually reads Rs / Rt
//   Ex_Rt, Ex_MemRead         EX-stage destination and load flag
//   Ex_BranchTaken            branch/jump resolved taken in EX
//   Mem_Wait                  data memory busy, whole pipeline frozen
//   PCWrite, IF_ID_Write      front-end advance enables
//   Control_Unit_Sel          1 passes control into ID/EX, 0 injects a bubble
//   IF_ID_Flush               squash the wrong-path instruction in IF/ID
//   Stall_Reason              none / load-use / flush / mem-wait
//   Stall_Cnt, Flush_Cnt      saturating event counters
module multicycle_hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] Id_Rs,
   input  logic [REG_ADDR_W-1:0] Id_Rt,
   input  logic                  Id_UseRs,
   input  logic                  Id_UseRt,
   input  logic [REG_ADDR_W-1:0] Ex_Rt,
   input  logic                  Ex_MemRead,
   input  logic                  Ex_BranchTaken,
   input  logic                  Mem_Wait,
   output logic                  PCWrite,
   output logic                  IF_ID_Write,
   output logic                  Control_Unit_Sel,
   output logic                  IF_ID_Flush,
   output logic [1:0]            Stall_Reason,
   output logic [CNT_W-1:0]      Stall_Cnt,
   output logic [CNT_W-1:0]      Flush_Cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic       load_hit;
   reason_e    reason;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // The scoreboard ages even on bubble/flush cycles; only a memory freeze holds it
   load_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .LOAD_LAT   (LOAD_LAT)
   ) u_scoreboard (
      .clk     (clk),
      .rst     (rst),
      .advance (!Mem_Wait),
      .ex_load (Ex_MemRead),
      .ex_rd   (Ex_Rt),
      .src_rs  (Id_Rs),
      .use_rs  (Id_UseRs),
      .src_rt  (Id_Rt),
      .use_rt  (Id_UseRt),
      .hit     (load_hit)
   );

   // Freeze beats flush beats load-use: a taken branch makes the ID instruction
   // wrong-path, so any dependency it appears to have is irrelevant.
   always_comb begin
      PCWrite          = 1'b1;
      IF_ID_Write      = 1'b1;
      Control_Unit_Sel = 1'b1;
      IF_ID_Flush      = 1'b0;
      reason           = REASON_NONE;
      if (rst) begin
         PCWrite          = 1'b0;
         IF_ID_Write      = 1'b0;
         Control_Unit_Sel = 1'b0;
      end else if (Mem_Wait) begin
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         reason      = REASON_MEMWAIT;
      end else if (Ex_BranchTaken) begin
         IF_ID_Flush      = 1'b1;
         Control_Unit_Sel = 1'b0;
         reason           = REASON_FLUSH;
      end else if (load_hit) begin
         PCWrite          = 1'b0;
         IF_ID_Write      = 1'b0;
         Control_Unit_Sel = 1'b0;
         reason           = REASON_LOAD;
      end
   end

   assign Stall_Reason = reason;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (reason == REASON_LOAD && stall_cnt_q != CNT_MAX) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (reason == REASON_FLUSH && flush_cnt_q != CNT_MAX) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign Stall_Cnt = stall_cnt_q;
   assign Flush_Cnt = flush_cnt_q;

endmodule

// File: tb/tb_multicycle_hazard_unit.sv
// tb/tb_multicycle_hazard_unit.sv - self-checking bench for multicycle_hazard_unit
module tb_multicycle_hazard_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       use_rs = 1'b0, use_rt = 1'b0, ex_mr = 1'b0, br = 1'b0, mw = 1'b0;

   always #5 clk = ~clk;

   // Three instances: LOAD_LAT 1/2/3; the LOAD_LAT=2 one has 4-bit counters
   localparam int LAT  [3] = '{1, 2, 3};
   localparam int CMAX [3] = '{65535, 15, 65535};

   logic       pcw [3];
   logic       ifw [3];
   logic       cus [3];
   logic       fl  [3];
   logic [1:0] rsn [3];
   logic [15:0] sc0, fc0, sc2, fc2;
   logic [3:0]  sc1, fc1;

   multicycle_hazard_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
      .clk(clk), .rst(rst), .Id_Rs(id_rs), .Id_Rt(id_rt), .Id_UseRs(use_rs), .Id_UseRt(use_rt),
      .Ex_Rt(ex_rt), .Ex_MemRead(ex_mr), .Ex_BranchTaken(br), .Mem_Wait(mw),
      .PCWrite(pcw[0]), .IF_ID_Write(ifw[0]), .Control_Unit_Sel(cus[0]), .IF_ID_Flush(fl[0]),
      .Stall_Reason(rsn[0]), .Stall_Cnt(sc0), .Flush_Cnt(fc0));

   multicycle_hazard_unit #(.REG_ADDR_W(5), .LOAD_LAT(2), .CNT_W(4)) u_l2 (
      .clk(clk), .rst(rst), .Id_Rs(id_rs), .Id_Rt(id_rt), .Id_UseRs(use_rs), .Id_UseRt(use_rt),
      .Ex_Rt(ex_rt), .Ex_MemRead(ex_mr), .Ex_BranchTaken(br), .Mem_Wait(mw),
      .PCWrite(pcw[1]), .IF_ID_Write(ifw[1]), .Control_Unit_Sel(cus[1]), .IF_ID_Flush(fl[1]),
      .Stall_Reason(rsn[1]), .Stall_Cnt(sc1), .Flush_Cnt(fc1));

   multicycle_hazard_unit #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) u_l3 (
      .clk(clk), .rst(rst), .Id_Rs(id_rs), .Id_Rt(id_rt), .Id_UseRs(use_rs), .Id_UseRt(use_rt),
      .Ex_Rt(ex_rt), .Ex_MemRead(ex_mr), .Ex_BranchTaken(br), .Mem_Wait(mw),
      .PCWrite(pcw[2]), .IF_ID_Write(ifw[2]), .Control_Unit_Sel(cus[2]), .IF_ID_Flush(fl[2]),
      .Stall_Reason(rsn[2]), .Stall_Cnt(sc2), .Flush_Cnt(fc2));

   int checks = 0;
   int passes = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int d, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s lat%0d actual=%0d expected=%0d at %0t", name, LAT[d], act, exp, $time);
   endtask

   function automatic int scnt(input int d);
      return (d == 0) ? int'(sc0) : (d == 1) ? int'(sc1) : int'(sc2);
   endfunction

   function automatic int fcnt(input int d);
      return (d == 0) ? int'(fc0) : (d == 1) ? int'(fc1) : int'(fc2);
   endfunction

   // Reference model: a history of the destination of every load that left EX on an
   // advancing cycle (0 = no load). Data of a load is usable LOAD_LAT advances after
   // it was in EX, so the EX load plus the last LOAD_LAT-1 history slots are unsafe.
   int hist   [3][8];
   int mstall [3];
   int mflush [3];

   function automatic bit dep(input int rd);
      return rd != 0 && ((use_rs && id_rs == 5'(rd)) || (use_rt && id_rt == 5'(rd)));
   endfunction

   function automatic bit m_hit(input int d);
      bit h = ex_mr && dep(int'(ex_rt));
      for (int j = 0; j < LAT[d] - 1; j++) if (dep(hist[d][j])) h = 1'b1;
      return h;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            for (int j = 0; j < 8; j++) hist[d][j] = 0;
            mstall[d] = 0;
            mflush[d] = 0;
         end else if (!mw) begin
            if (br) mflush[d] = (mflush[d] < CMAX[d]) ? mflush[d] + 1 : mflush[d];
            else if (m_hit(d)) mstall[d] = (mstall[d] < CMAX[d]) ? mstall[d] + 1 : mstall[d];
            for (int j = 7; j > 0; j--) hist[d][j] = hist[d][j-1];
            hist[d][0] = ex_mr ? int'(ex_rt) : 0;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 3; d++) begin
            int e_pcw, e_ifw, e_cus, e_fl, e_rsn;
            if (rst) begin
               e_pcw = 0; e_ifw = 0; e_cus = 0; e_fl = 0; e_rsn = 0;
            end else if (mw) begin
               e_pcw = 0; e_ifw = 0; e_cus = 1; e_fl = 0; e_rsn = 3;
            end else if (br) begin
               e_pcw = 1; e_ifw = 1; e_cus = 0; e_fl = 1; e_rsn = 2;
            end else if (m_hit(d)) begin
               e_pcw = 0; e_ifw = 0; e_cus = 0; e_fl = 0; e_rsn = 1;
            end else begin
               e_pcw = 1; e_ifw = 1; e_cus = 1; e_fl = 0; e_rsn = 0;
            end
            check("pcwrite", d, int'(pcw[d]), e_pcw);
            check("if_id_write", d, int'(ifw[d]), e_ifw);
            check("ctrl_sel", d, int'(cus[d]), e_cus);
            check("if_id_flush", d, int'(fl[d]), e_fl);
            check("stall_reason", d, int'(rsn[d]), e_rsn);
            check("stall_cnt", d, scnt(d), mstall[d]);
            check("flush_cnt", d, fcnt(d), mflush[d]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = '0; id_rt = '0; use_rs = 0; use_rt = 0;
      ex_rt = '0; ex_mr = 0; br = 0; mw = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step();
      rst = 0;
   endtask

   initial begin
      #1;
      do_reset();
      chk_en = 1'b1;

      // Consumer directly behind a load to r5, LOAD_LAT=2: stall cycles 0 and 1
      ex_mr = 1; ex_rt = 5; id_rs = 5; use_rs = 1;
      #2;
      check("t1_c0_pcw", 1, int'(pcw[1]), 0);
      check("t1_c0_sel", 1, int'(cus[1]), 0);
      step();
      ex_mr = 0; ex_rt = 0;
      #2;
      check("t1_c1_pcw", 1, int'(pcw[1]), 0);
      check("t1_c1_sel", 1, int'(cus[1]), 0);
      check("t1_c1_l1_pcw", 0, int'(pcw[0]), 1);
      step();
      #2;
      check("t1_c2_pcw", 1, int'(pcw[1]), 1);
      check("t1_c2_sel", 1, int'(cus[1]), 1);
      check("t1_stall_cnt", 1, scnt(1), 2);

      // LOAD_LAT=1: load to r0, and an unused matching Rt, never stall
      do_reset();
      ex_mr = 1; ex_rt = 0; id_rs = 0; use_rs = 1;
      #2;
      check("t2_r0_reason", 0, int'(rsn[0]), 0);
      step();
      ex_rt = 7; id_rt = 7; use_rt = 0; id_rs = 3; use_rs = 0;
      #2;
      check("t2_nouse_reason", 0, int'(rsn[0]), 0);
      step();

      // LOAD_LAT=3: pending hazard overridden by a taken branch
      do_reset();
      ex_mr = 1; ex_rt = 9; id_rs = 9; use_rs = 1;
      #2;
      check("t3_c0_reason", 2, int'(rsn[2]), 1);
      step();
      ex_mr = 0; ex_rt = 0; br = 1;
      #2;
      check("t3_flush", 2, int'(fl[2]), 1);
      check("t3_pcw", 2, int'(pcw[2]), 1);
      check("t3_reason", 2, int'(rsn[2]), 2);
      step();
      br = 0;
      #2;
      check("t3_flush_cnt", 2, fcnt(2), 1);
      check("t3_stall_cnt", 2, scnt(2), 1);

      // LOAD_LAT=2: memory wait during the second stall cycle extends the stall
      do_reset();
      ex_mr = 1; ex_rt = 4; id_rs = 4; use_rs = 1;
      #2;
      check("t4_c0_reason", 1, int'(rsn[1]), 1);
      step();
      ex_mr = 0; ex_rt = 0; mw = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("t4_mw_reason", 1, int'(rsn[1]), 3);
         step();
      end
      mw = 0;
      #2;
      check("t4_resume_reason", 1, int'(rsn[1]), 1);
      step();
      #2;
      check("t4_release_reason", 1, int'(rsn[1]), 0);
      check("t4_stall_cnt", 1, scnt(1), 2);

      // 4-bit counter saturation, then reset empties everything
      do_reset();
      ex_mr = 1; ex_rt = 5; id_rs = 5; use_rs = 1;
      repeat (20) step();
      #2;
      check("t5_sat", 1, scnt(1), 15);
      rst = 1;
      #1;
      check("t5_rst_pcw", 1, int'(pcw[1]), 0);
      step();
      rst = 0; ex_mr = 0; ex_rt = 0;
      #2;
      check("t5_cnt_clr", 1, scnt(1), 0);
      for (int d = 0; d < 3; d++) check("t5_no_stall", d, int'(pcw[d]), 1);
      step();

      // Randomised traffic over a small register range to provoke dependencies
      for (int n = 0; n < 2000; n++) begin
         rst    = ($urandom_range(0, 99) == 0);
         mw     = ($urandom_range(0, 9) == 0);
         br     = ($urandom_range(0, 11) == 0);
         ex_mr  = 1'($urandom_range(0, 1));
         ex_rt  = 5'($urandom_range(0, 3));
         id_rs  = 5'($urandom_range(0, 3));
         id_rt  = 5'($urandom_range(0, 3));
         use_rs = 1'($urandom_range(0, 1));
         use_rt = 1'($urandom_range(0, 1));
         step();
      end
      rst = 0;
      idle_inputs();
      step();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
